// File: rtl/band_gain_seq.sv
// Five-band slider gain stage: one shared signed multiplier is stepped over LP,B1,B2,B3,HP,
// and all five saturated results are published together with a single-cycle valid strobe.
module band_gain_seq #(
   parameter int GAIN_W = 12,
   parameter int SHIFT  = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vld_in,
   input  logic signed [15:0]       smp_LP,
   input  logic signed [15:0]       smp_B1,
   input  logic signed [15:0]       smp_B2,
   input  logic signed [15:0]       smp_B3,
   input  logic signed [15:0]       smp_HP,
   input  logic [GAIN_W-1:0]        gain_LP,
   input  logic [GAIN_W-1:0]        gain_B1,
   input  logic [GAIN_W-1:0]        gain_B2,
   input  logic [GAIN_W-1:0]        gain_B3,
   input  logic [GAIN_W-1:0]        gain_HP,
   output logic signed [15:0]       out_LP,
   output logic signed [15:0]       out_B1,
   output logic signed [15:0]       out_B2,
   output logic signed [15:0]       out_B3,
   output logic signed [15:0]       out_HP,
   output logic                     out_vld,
   output logic                     busy,
   output logic                     ovr
);

   localparam int PW = GAIN_W + 17;
   localparam logic signed [PW-1:0] MAX_V = PW'(32767);
   localparam logic signed [PW-1:0] MIN_V = PW'(-32768);

   typedef enum logic [1:0] {IDLE, MUL, XFER} state_t;

   state_t                   state_reg, state_next;
   logic [2:0]               idx_reg;
   logic signed [15:0]       smp_in   [0:4];
   logic [GAIN_W-1:0]        gain_in  [0:4];
   logic signed [15:0]       smp_reg  [0:4];
   logic [GAIN_W-1:0]        gain_reg [0:4];
   logic signed [15:0]       shadow_reg [0:4];
   logic signed [15:0]       out_reg  [0:4];
   logic                     out_vld_reg;
   logic                     ovr_reg;

   logic signed [PW-1:0]     prod;
   logic signed [PW-1:0]     shifted;
   logic signed [15:0]       sat;

   assign smp_in[0]  = smp_LP;
   assign smp_in[1]  = smp_B1;
   assign smp_in[2]  = smp_B2;
   assign smp_in[3]  = smp_B3;
   assign smp_in[4]  = smp_HP;
   assign gain_in[0] = gain_LP;
   assign gain_in[1] = gain_B1;
   assign gain_in[2] = gain_B2;
   assign gain_in[3] = gain_B3;
   assign gain_in[4] = gain_HP;

   // Gain is zero-extended so the multiply stays signed; floor shift, then clamp (never wrap).
   always_comb begin
      prod    = PW'(smp_reg[idx_reg]) * PW'(signed'({1'b0, gain_reg[idx_reg]}));
      shifted = prod >>> SHIFT;
      if (shifted > MAX_V)
         sat = 16'sh7FFF;
      else if (shifted < MIN_V)
         sat = 16'sh8000;
      else
         sat = shifted[15:0];
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (vld_in) state_next = MUL;
         MUL:     if (idx_reg == 3'd4) state_next = XFER;
         XFER:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg     <= 3'd0;
         out_vld_reg <= 1'b0;
         ovr_reg     <= 1'b0;
         for (int i = 0; i < 5; i++) begin
            smp_reg[i]    <= '0;
            gain_reg[i]   <= '0;
            shadow_reg[i] <= '0;
            out_reg[i]    <= '0;
         end
      end else begin
         out_vld_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (vld_in) begin
                  idx_reg <= 3'd0;
                  for (int i = 0; i < 5; i++) begin
                     smp_reg[i]  <= smp_in[i];
                     gain_reg[i] <= gain_in[i];
                  end
               end
            end
            MUL: begin
               shadow_reg[idx_reg] <= sat;
               idx_reg             <= idx_reg + 3'd1;
            end
            XFER: begin
               out_vld_reg <= 1'b1;
               for (int i = 0; i < 5; i++)
                  out_reg[i] <= shadow_reg[i];
            end
            default: ;
         endcase
         // Anything arriving outside IDLE, including the publish edge, is lost.
         if (vld_in && state_reg != IDLE)
            ovr_reg <= 1'b1;
      end
   end

   assign out_LP  = out_reg[0];
   assign out_B1  = out_reg[1];
   assign out_B2  = out_reg[2];
   assign out_B3  = out_reg[3];
   assign out_HP  = out_reg[4];
   assign out_vld = out_vld_reg;
   assign busy    = (state_reg != IDLE);
   assign ovr     = ovr_reg;

endmodule

// File: tb/tb_band_gain_seq.sv
// Randomized scoreboard bench for band_gain_seq: stimulus pushes expected band results,
// a negedge monitor pops and compares whenever out_vld is seen.
module tb_band_gain_seq;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              vld_in;
   logic signed [15:0] smp_d [5];
   logic [11:0]        gain_d [5];
   logic signed [15:0] out_LP, out_B1, out_B2, out_B3, out_HP;
   logic              out_vld, busy, ovr;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_acc = -1000;
   logic ovr_exp = 1'b0;
   int exp_q[$];
   int held[5];
   string bn[5] = '{"LP", "B1", "B2", "B3", "HP"};

   band_gain_seq #(.GAIN_W(12), .SHIFT(10)) dut (
      .clk(clk), .rst_n(rst_n), .vld_in(vld_in),
      .smp_LP(smp_d[0]), .smp_B1(smp_d[1]), .smp_B2(smp_d[2]), .smp_B3(smp_d[3]), .smp_HP(smp_d[4]),
      .gain_LP(gain_d[0]), .gain_B1(gain_d[1]), .gain_B2(gain_d[2]), .gain_B3(gain_d[3]),
      .gain_HP(gain_d[4]),
      .out_LP(out_LP), .out_B1(out_B1), .out_B2(out_B2), .out_B3(out_B3), .out_HP(out_HP),
      .out_vld(out_vld), .busy(busy), .ovr(ovr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // Gain as a real ratio g/1024, rounded toward -infinity, clamped to the 16-bit range.
   function automatic int ref_gain(input int s, input int g);
      longint p, q;
      p = longint'(s) * longint'(g);
      if (p >= 0) q = p / 1024;
      else        q = -((-p + 1023) / 1024);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return int'(q);
   endfunction

   function automatic int out_of(input int i);
      case (i)
         0: return int'(out_LP);
         1: return int'(out_B1);
         2: return int'(out_B2);
         3: return int'(out_B3);
         default: return int'(out_HP);
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_all(input int s, input int g);
      for (int i = 0; i < 5; i++) begin
         smp_d[i]  = 16'(s);
         gain_d[i] = 12'(g);
      end
   endtask

   task automatic randomize_inputs();
      for (int i = 0; i < 5; i++) begin
         case ($urandom_range(0, 5))
            0:       smp_d[i] = 16'sh7FFF;
            1:       smp_d[i] = 16'sh8000;
            default: smp_d[i] = 16'($urandom);
         endcase
         gain_d[i] = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
      end
   endtask

   // A pulse is accepted only if at least 7 clocks have passed since the last accepted one.
   task automatic issue();
      @(negedge clk);
      vld_in = 1'b1;
      if (cyc - last_acc >= 7) begin
         last_acc = cyc;
         exp_q.push_back(cyc + 7);
         for (int i = 0; i < 5; i++)
            exp_q.push_back(ref_gain(int'(smp_d[i]), int'(gain_d[i])));
         $display("issue t=%0t accepted", $time);
      end else begin
         ovr_exp = 1'b1;
         $display("issue t=%0t dropped", $time);
      end
      @(negedge clk);
      vld_in = 1'b0;
      chk("ovr", int'(ovr), int'(ovr_exp));
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (out_vld) begin
            if (exp_q.size() < 6) begin
               chk("spurious_out_vld", 1, 0);
            end else begin
               chk("latency", cyc, exp_q.pop_front());
               for (int i = 0; i < 5; i++) begin
                  held[i] = exp_q.pop_front();
                  chk({"out_", bn[i]}, out_of(i), held[i]);
               end
               $display("out_vld t=%0t LP=%0d B1=%0d B2=%0d B3=%0d HP=%0d",
                        $time, out_LP, out_B1, out_B2, out_B3, out_HP);
            end
         end else begin
            int same;
            same = 1;
            for (int i = 0; i < 5; i++)
               if (out_of(i) != held[i]) same = 0;
            chk("hold", same, 1);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bcnt;
      rst_n = 1'b0;
      vld_in = 1'b0;
      set_all(0, 0);
      for (int i = 0; i < 5; i++) held[i] = 0;
      idle(2);
      chk("rst_out_vld", int'(out_vld), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ovr", int'(ovr), 0);
      chk("rst_out_LP", int'(out_LP), 0);
      rst_n = 1'b1;
      idle(2);

      // Unity gain with busy-width measurement
      set_all(1000, 1024);
      issue();
      bcnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (busy) bcnt++;
         @(negedge clk);
      end
      chk("busy_cycles", bcnt, 6);

      // Per-band rounding, inputs scrambled right after capture
      smp_d[0] = 16'sd1000;  gain_d[0] = 12'd512;
      smp_d[1] = -16'sd3;    gain_d[1] = 12'd512;
      smp_d[2] = -16'sd1;    gain_d[2] = 12'd1;
      smp_d[3] = 16'sd0;     gain_d[3] = 12'd4095;
      smp_d[4] = 16'sd32767; gain_d[4] = 12'd0;
      issue();
      randomize_inputs();
      idle(8);

      // Saturation corners
      smp_d[0] = 16'sd16384;  gain_d[0] = 12'd4095;
      smp_d[1] = -16'sd16384; gain_d[1] = 12'd4095;
      smp_d[2] = 16'sh8000;   gain_d[2] = 12'd1024;
      smp_d[3] = 16'sd32767;  gain_d[3] = 12'd4095;
      smp_d[4] = 16'sh8000;   gain_d[4] = 12'd4095;
      issue();
      idle(8);

      // Overrun: +3 clocks dropped, +7 clocks accepted
      set_all(2000, 2048);
      issue();
      idle(1);
      set_all(-500, 100);
      issue();
      idle(2);
      set_all(-1234, 3000);
      issue();
      idle(8);

      // Reset in the middle of MUL abandons the computation
      set_all(700, 900);
      issue();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_out_vld", int'(out_vld), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_ovr", int'(ovr), 0);
      chk("midrst_out_LP", int'(out_LP), 0);
      chk("midrst_out_HP", int'(out_HP), 0);
      exp_q.delete();
      for (int i = 0; i < 5; i++) held[i] = 0;
      ovr_exp = 1'b0;
      last_acc = -1000;
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Random traffic with random spacing (some pulses land while busy)
      for (int t = 0; t < 40; t++) begin
         randomize_inputs();
         issue();
         randomize_inputs();
         idle($urandom_range(0, 8));
      end

      for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      idle(3);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
